// File: rtl/game_pkg.sv
// Shared match definitions: rally state encodings and player identifiers.
// Also used by the score overlay and the UART mux.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        RALLY      = 3'd2,
        POINT      = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    typedef enum logic {
        PL1 = 1'b0,
        PL2 = 1'b1
    } player_t;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned FRAME_W = 8;

endpackage

// File: rtl/frame_timer.sv
// Frame tick generator and saturating frame counter.
// A tick is the rising edge of the registered vblnk; the counter advances on
// ticks only and is cleared synchronously by clr. done flags the tick that
// brings the count up to limit; expired means limit ticks have already elapsed.
module frame_timer
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               vblnk,
    input  logic               clr,
    input  logic [FRAME_W-1:0] limit,
    output logic               done,
    output logic               expired
);

    logic               vblnk_q;
    logic               vblnk_qq;
    logic               tick;
    logic [FRAME_W-1:0] count;

    // Register vblnk twice so its rising edge can be detected as a one-cycle tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_q  <= 1'b0;
            vblnk_qq <= 1'b0;
        end else begin
            vblnk_q  <= vblnk;
            vblnk_qq <= vblnk_q;
        end
    end

    assign tick = vblnk_q & ~vblnk_qq;

    // Saturating tick counter; clear wins over a coincident tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Compare is done one bit wider so a saturated count cannot wrap into a match
    always_comb begin
        done    = tick && (({1'b0, count} + 9'd1) == {1'b0, limit});
        expired = (count >= limit);
    end

endmodule

// File: rtl/match_ctrl.sv
// Blobby Volley match sequencer: rally state machine, fault-to-score
// conversion, ball freeze/re-arm and score/endgame publishing.
// All outputs are registered; state is written as state register,
// next-state logic, and output next-value logic feeding output registers.
module match_ctrl
    import game_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 15,
    parameter int unsigned NET_X        = 512,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned SERVE_FRAMES = 180,
    parameter int unsigned OVER_FRAMES  = 120
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vblnk_in,
    input  logic         start_click,
    input  logic         gnd_col,
    input  logic         ovr_touch,
    input  logic         last_touch,
    input  logic [11:0]  ball_xpos,
    output logic [3:0]   score_pl1,
    output logic [3:0]   score_pl2,
    output logic         ball_hold,
    output logic         ball_reset,
    output logic         serve_side,
    output logic         endgame,
    output logic         winner,
    output logic [2:0]   state_out
);

    localparam logic [11:0]        NET_X_L   = 12'(NET_X);
    localparam logic [SCORE_W-1:0] WIN_L     = SCORE_W'(WIN_SCORE);
    localparam logic [FRAME_W-1:0] POINT_L   = FRAME_W'(POINT_FRAMES);
    localparam logic [FRAME_W-1:0] SERVE_L   = FRAME_W'(SERVE_FRAMES);
    localparam logic [FRAME_W-1:0] OVER_L    = FRAME_W'(OVER_FRAMES);

    state_t               state;
    state_t               next_state;

    logic                 click_q1;
    logic                 click_q2;
    logic                 click_rise;

    logic                 timer_clr;
    logic [FRAME_W-1:0]   timer_limit;
    logic                 timer_done;
    logic                 timer_expired;

    logic                 fault;
    player_t              scorer;
    logic [SCORE_W-1:0]   scorer_new;
    logic                 win;

    logic [SCORE_W-1:0]   score_pl1_d;
    logic [SCORE_W-1:0]   score_pl2_d;
    logic                 serve_side_d;
    logic                 endgame_d;
    logic                 winner_d;
    logic                 ball_reset_d;
    logic                 ball_hold_d;

    frame_timer u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .vblnk   (vblnk_in),
        .clr     (timer_clr),
        .limit   (timer_limit),
        .done    (timer_done),
        .expired (timer_expired)
    );

    // Two-flop registered copy of the mouse button for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            click_q1 <= 1'b0;
            click_q2 <= 1'b0;
        end else begin
            click_q1 <= start_click;
            click_q2 <= click_q1;
        end
    end

    assign click_rise = click_q1 & ~click_q2;

    // Select the frame limit of the current state and clear the timer on every state entry
    always_comb begin
        unique case (state)
            SERVE_WAIT: timer_limit = SERVE_L;
            POINT:      timer_limit = POINT_L;
            GAME_OVER:  timer_limit = OVER_L;
            default:    timer_limit = '1;
        endcase
        timer_clr = (next_state != state);
    end

    // Decide who scores: a third-touch fault outranks a ground contact
    always_comb begin
        fault = ovr_touch | gnd_col;
        if (ovr_touch) begin
            scorer = player_t'(~last_touch);
        end else if (ball_xpos < NET_X_L) begin
            scorer = PL2;
        end else begin
            scorer = PL1;
        end
        scorer_new = ((scorer == PL1) ? score_pl1 : score_pl2) + 1'b1;
        win        = (scorer_new == WIN_L);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (click_rise) next_state = SERVE_WAIT;
            end
            SERVE_WAIT: begin
                if ((click_rise && (serve_side == PL1)) || timer_done) next_state = RALLY;
            end
            RALLY: begin
                if (fault) next_state = win ? GAME_OVER : POINT;
            end
            POINT: begin
                if (timer_done) next_state = SERVE_WAIT;
            end
            GAME_OVER: begin
                if (click_rise && timer_expired) next_state = SERVE_WAIT;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output next values, derived from the current state and the chosen transition
    always_comb begin
        score_pl1_d  = score_pl1;
        score_pl2_d  = score_pl2;
        serve_side_d = serve_side;
        endgame_d    = endgame;
        winner_d     = winner;
        ball_reset_d = 1'b0;
        ball_hold_d  = (next_state != RALLY);
        unique case (state)
            IDLE: begin
                score_pl1_d = '0;
                score_pl2_d = '0;
                if (next_state == SERVE_WAIT) begin
                    ball_reset_d = 1'b1;
                    serve_side_d = PL1;
                end
            end
            RALLY: begin
                if (fault) begin
                    if (scorer == PL1) score_pl1_d = scorer_new;
                    else               score_pl2_d = scorer_new;
                    serve_side_d = scorer;
                    if (win) begin
                        endgame_d = 1'b1;
                        winner_d  = scorer;
                    end
                end
            end
            POINT: begin
                if (next_state == SERVE_WAIT) ball_reset_d = 1'b1;
            end
            GAME_OVER: begin
                if (next_state == SERVE_WAIT) begin
                    score_pl1_d  = '0;
                    score_pl2_d  = '0;
                    endgame_d    = 1'b0;
                    winner_d     = PL1;
                    serve_side_d = PL1;
                    ball_reset_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_pl1  <= '0;
            score_pl2  <= '0;
            serve_side <= 1'b0;
            endgame    <= 1'b0;
            winner     <= 1'b0;
            ball_reset <= 1'b0;
            ball_hold  <= 1'b1;
        end else begin
            score_pl1  <= score_pl1_d;
            score_pl2  <= score_pl2_d;
            serve_side <= serve_side_d;
            endgame    <= endgame_d;
            winner     <= winner_d;
            ball_reset <= ball_reset_d;
            ball_hold  <= ball_hold_d;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl: expected status is queued before each
// stimulus step and popped against the DUT outputs once the step completes.
module tb_match_ctrl;

    logic        clk;
    logic        rst;
    logic        vblnk_in;
    logic        start_click;
    logic        gnd_col;
    logic        ovr_touch;
    logic        last_touch;
    logic [11:0] ball_xpos;
    logic [3:0]  score_pl1;
    logic [3:0]  score_pl2;
    logic        ball_hold;
    logic        ball_reset;
    logic        serve_side;
    logic        endgame;
    logic        winner;
    logic [2:0]  state_out;

    match_ctrl #(
        .WIN_SCORE    (15),
        .NET_X        (512),
        .POINT_FRAMES (90),
        .SERVE_FRAMES (180),
        .OVER_FRAMES  (120)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vblnk_in    (vblnk_in),
        .start_click (start_click),
        .gnd_col     (gnd_col),
        .ovr_touch   (ovr_touch),
        .last_touch  (last_touch),
        .ball_xpos   (ball_xpos),
        .score_pl1   (score_pl1),
        .score_pl2   (score_pl2),
        .ball_hold   (ball_hold),
        .ball_reset  (ball_reset),
        .serve_side  (serve_side),
        .endgame     (endgame),
        .winner      (winner),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of the match
    int   p1 = 0;
    int   p2 = 0;
    int   ss = 0;
    int   eg = 0;
    int   wn = 0;

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d expected an entry", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_status(input int st, input int hold, input int rs);
        push("state", st);
        push("score_pl1", p1);
        push("score_pl2", p2);
        push("serve_side", ss);
        push("ball_hold", hold);
        push("ball_reset", rs);
        push("endgame", eg);
        push("winner", wn);
    endtask

    task automatic check_status();
        pop_check(32'(state_out));
        pop_check(32'(score_pl1));
        pop_check(32'(score_pl2));
        pop_check(32'(serve_side));
        pop_check(32'(ball_hold));
        pop_check(32'(ball_reset));
        pop_check(32'(endgame));
        pop_check(32'(winner));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame tick; its effect is visible when the task returns
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            vblnk_in = 1'b1;
            cyc(1);
            vblnk_in = 1'b0;
            cyc(1);
        end
    endtask

    // One mouse click; its effect is visible when the task returns
    task automatic click();
        start_click = 1'b1;
        cyc(1);
        start_click = 1'b0;
        cyc(1);
    endtask

    // Apply a one-cycle fault in RALLY and check the resulting status
    task automatic fault(input logic g, input logic o, input logic lt, input int x);
        int sc;
        int ns;
        int st;
        if (o) sc = lt ? 0 : 1;
        else   sc = (x < 512) ? 1 : 0;
        if (sc == 0) begin p1++; ns = p1; end
        else         begin p2++; ns = p2; end
        ss = sc;
        st = 3;
        if (ns == 15) begin
            eg = 1;
            wn = sc;
            st = 4;
        end
        expect_status(st, 1, 0);
        gnd_col    = g;
        ovr_touch  = o;
        last_touch = lt;
        ball_xpos  = 12'(x);
        cyc(1);
        gnd_col   = 1'b0;
        ovr_touch = 1'b0;
        check_status();
    endtask

    // From POINT: wait out the pause, then release the serve
    task automatic serve();
        expect_status(1, 1, 1);
        ticks(90);
        check_status();
        expect_status(2, 0, 0);
        if (ss == 0) click();
        else         ticks(180);
        check_status();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b0;
        vblnk_in    = 1'b0;
        start_click = 1'b0;
        gnd_col     = 1'b0;
        ovr_touch   = 1'b0;
        last_touch  = 1'b0;
        ball_xpos   = '0;

        expect_status(0, 1, 0);
        cyc(3);
        check_status();
        rst = 1'b1;
        cyc(2);

        // Start and first serve
        expect_status(1, 1, 1);
        click();
        check_status();
        expect_status(1, 1, 0);
        cyc(1);
        check_status();
        expect_status(2, 0, 0);
        click();
        check_status();

        // Ground fault on pl1 half
        fault(1'b1, 1'b0, 1'b0, 300);

        // Faults ignored during POINT
        expect_status(3, 1, 0);
        gnd_col   = 1'b1;
        ovr_touch = 1'b1;
        cyc(3);
        gnd_col   = 1'b0;
        ovr_touch = 1'b0;
        check_status();

        // POINT pause boundary
        expect_status(3, 1, 0);
        ticks(89);
        check_status();
        expect_status(1, 1, 1);
        ticks(1);
        check_status();
        expect_status(1, 1, 0);
        cyc(1);
        check_status();

        // pl2 serves: a click is ignored, auto release on tick 180
        expect_status(1, 1, 0);
        ticks(10);
        click();
        check_status();
        expect_status(1, 1, 0);
        ticks(169);
        check_status();
        expect_status(2, 0, 0);
        ticks(1);
        check_status();

        // Simultaneous faults: third-touch wins, only one point
        fault(1'b1, 1'b1, 1'b1, 700);
        expect_status(3, 1, 0);
        gnd_col = 1'b1;
        cyc(4);
        gnd_col = 1'b0;
        check_status();

        // Priority case where the two faults disagree on the scorer
        serve();
        fault(1'b1, 1'b1, 1'b0, 700);

        // Net boundary on both sides
        serve();
        fault(1'b1, 1'b0, 1'b0, 511);
        serve();
        fault(1'b1, 1'b0, 1'b0, 512);

        // Run pl1 up to the winning point
        while (p1 < 15) begin
            serve();
            fault(1'b1, 1'b0, 1'b0, 700);
        end

        // GAME_OVER: early clicks ignored, click after 120 ticks restarts
        expect_status(4, 1, 0);
        ticks(50);
        click();
        check_status();
        expect_status(4, 1, 0);
        ticks(69);
        click();
        check_status();
        ticks(1);
        p1 = 0;
        p2 = 0;
        ss = 0;
        eg = 0;
        wn = 0;
        expect_status(1, 1, 1);
        click();
        check_status();

        // Reset mid-rally with a nonzero score
        expect_status(2, 0, 0);
        click();
        check_status();
        fault(1'b1, 1'b0, 1'b0, 700);
        serve();
        rst = 1'b0;
        push("async_reset_state", 0);
        #2;
        pop_check(32'(state_out));
        p1 = 0;
        p2 = 0;
        ss = 0;
        eg = 0;
        wn = 0;
        expect_status(0, 1, 0);
        cyc(1);
        check_status();
        rst = 1'b1;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Match sequencer for the Blobby Volley game, clocked on the 65 MHz pixel clock. It owns the rally state machine: start, serve hold, rally, point pause and game over. It converts ground and third-touch faults into score updates, freezes and re-arms the ball controller, and publishes scores and the end-of-game flag to the score overlay and the UART mux.

## Interface
Parameters:
- WIN_SCORE, 15: score that ends the match (4-bit scores, 1..15)
- NET_X, 512: ball x below this is player 1's half; at or above it is player 2's half
- POINT_FRAMES, 90: frames held in POINT before the next serve
- SERVE_FRAMES, 180: frames after which SERVE_WAIT auto-releases
- OVER_FRAMES, 120: minimum frames in GAME_OVER before a restart is accepted

Ports:
- clk  in  1  65 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- vblnk_in  in  1  vertical blank from vga timing; its rising edge is the frame tick
- start_click  in  1  player-1 mouse left button, level
- gnd_col  in  1  ball touching ground, level
- ovr_touch  in  1  third-touch fault from judge logic, level
- last_touch  in  1  last player to touch the ball (0 = pl1, 1 = pl2)
- ball_xpos  in  12  ball x position
- score_pl1  out  4  player 1 score
- score_pl2  out  4  player 2 score
- ball_hold  out  1  freezes ball physics
- ball_reset  out  1  one-cycle pulse; reload ball to serve position
- serve_side  out  1  serving player (0 = pl1, 1 = pl2)
- endgame  out  1  match finished
- winner  out  1  valid when endgame = 1 (0 = pl1)
- state_out  out  3  current state encoding

## Operation
- States: IDLE, SERVE_WAIT, RALLY, POINT, GAME_OVER.
- IDLE:
  - ball_hold = 1, scores = 0.
  - Rising edge of start_click: ball_reset pulse, serve_side = 0, go to SERVE_WAIT.
- SERVE_WAIT:
  - ball_hold = 1.
  - Frame counter clears on entry.
  - Start_click rising edge while serve_side = 0 releases to RALLY.
  - Otherwise the state releases to RALLY when the counter reaches SERVE_FRAMES.
- RALLY:
  - ball_hold = 0.
  - Fault priority: ovr_touch over gnd_col.
  - On ovr_touch, the scorer is ~last_touch.
  - On gnd_col, the scorer is pl2 if ball_xpos < NET_X, otherwise pl1.
  - The scorer's score increments. serve_side becomes the scorer. Go to POINT.
  - If the new score equals WIN_SCORE, go to GAME_OVER instead, with endgame = 1 and winner = scorer.
- POINT:
  - ball_hold = 1; all fault inputs are ignored.
  - After POINT_FRAMES frame ticks: ball_reset pulse, go to SERVE_WAIT.
- GAME_OVER:
  - ball_hold = 1; scores are frozen.
  - A start_click rising edge after OVER_FRAMES frame ticks clears scores, endgame and winner, pulses ball_reset, sets serve_side = 0 and goes to SERVE_WAIT.
  - Clicks earlier than OVER_FRAMES are ignored.
- Faults are accepted only in RALLY. A fault level still held on the RALLY entry cycle counts.
- Frame counter: 8 bits, cleared on every state entry, saturating. Parameters above 255 are illegal.

## Timing
- All outputs are registered.
- Reset values: scores 0, ball_hold 1, ball_reset 0, serve_side 0, endgame 0, winner 0, state IDLE.
- Fault sampled in RALLY on edge N: the new score, state, serve_side and endgame are all visible after edge N. Latency is one cycle.
- ball_reset is high for exactly one cycle: the first cycle the new state is visible.
- Frame tick:
  - The tick is a one-cycle pulse on the rising edge of the registered vblnk_in.
  - The counter increments on ticks only.
  - The transition occurs on the tick that makes count == limit.
- Start_click edge detection uses a 2-flop registered copy.
- Asserting reset mid-match returns to IDLE immediately and clears all state. No ball_reset pulse is generated on reset.

## Structure
- Shared package game_pkg: state encodings (IDLE = 0, SERVE_WAIT = 1, RALLY = 2, POINT = 3, GAME_OVER = 4) and player IDs. These are reused by the score overlay and the UART mux.
- One sub-module, frame_timer: vblnk edge detect, 8-bit saturating counter, clear input and `done` compare against a limit input.

## Test plan
- Reset low mid-RALLY with scores 3:2 -> next cycle state_out = 0, scores 0:0, ball_hold = 1, ball_reset = 0.
- IDLE, start_click rising edge -> ball_reset pulse of 1 cycle, state_out = 1. A second click -> state_out = 2 and ball_hold = 0 on the following cycle.
- RALLY, gnd_col = 1 with ball_xpos = 300 -> score_pl2 increments by 1, serve_side = 1, state_out = 3. After 90 ticks -> ball_reset pulse, state_out = 1.
- RALLY, gnd_col and ovr_touch asserted together, last_touch = 1, ball_xpos = 700 -> score_pl1 increments by 1 (ovr_touch priority, pl2 faulted), not a second point.
- SERVE_WAIT with serve_side = 1, no clicks -> RALLY exactly on tick 180. A click at tick 10 -> no release.
- score_pl1 = 14, ground fault on pl2's half -> score_pl1 = 15, endgame = 1, winner = 0, state_out = 4. Click at tick 50 ignored. Click after tick 120 -> scores 0:0, state_out = 1.
